// File: rtl/gpio_pkg.sv
// Shared register map and constants for the APB GPIO port with interrupts.
package gpio_pkg;
  localparam logic [15:0] DATA_OFF    = 16'h0000;
  localparam logic [15:0] DIR_OFF     = 16'h0004;
  localparam logic [15:0] OUT_SET_OFF = 16'h0008;
  localparam logic [15:0] OUT_CLR_OFF = 16'h000C;
  localparam logic [15:0] OUT_TGL_OFF = 16'h0010;
  localparam logic [15:0] IE_OFF      = 16'h0014;
  localparam logic [15:0] ITYPE_OFF   = 16'h0018;
  localparam logic [15:0] IPOL_OFF    = 16'h001C;
  localparam logic [15:0] IBOTH_OFF   = 16'h0020;
  localparam logic [15:0] ISTAT_OFF   = 16'h0024;
  localparam logic [15:0] IMSTAT_OFF  = 16'h0028;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;
endpackage

// File: rtl/gpio_sync_edge.sv
// Pad synchroniser plus per-pin edge/level event generator, with events
// held off after reset until the chain and its delay flop hold real pad data.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk_i,
  input  logic             presetn_i,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [WIDTH-1:0] itype_i,
  input  logic [WIDTH-1:0] ipol_i,
  input  logic [WIDTH-1:0] iboth_i,
  output logic [WIDTH-1:0] sin_o,
  output logic [WIDTH-1:0] evt_o
);
  localparam int              CW   = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]   HOLD = CW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sin;
  logic [WIDTH-1:0]                  sin_q;
  logic [CW-1:0]                     hold_q;
  logic [CW-1:0]                     hold_d;
  logic [WIDTH-1:0]                  edge_evt;
  logic [WIDTH-1:0]                  level_evt;

  assign sin = sync_q[SYNC_STAGES-1];

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      sync_q <= '0;
      sin_q  <= '0;
      hold_q <= HOLD;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      sin_q  <= sin;
      hold_q <= hold_d;
    end
  end

  // Down-counter: events are enabled only once it reaches terminal count.
  assign hold_d = (hold_q != '0) ? hold_q - CW'(1) : hold_q;

  always_comb begin
    edge_evt  = (iboth_i & (sin ^ sin_q))
              | (~iboth_i &  ipol_i &  sin & ~sin_q)
              | (~iboth_i & ~ipol_i & ~sin &  sin_q);
    level_evt = ~(sin ^ ipol_i);
  end

  assign evt_o = (hold_q == '0) ? ((itype_i & edge_evt) | (~itype_i & level_evt)) : '0;
  assign sin_o = sin;
endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO port: output/direction registers with atomic set/clear/toggle,
// per-pin interrupt configuration, sticky W1C status and a registered IRQ.
module apb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [31:0]      PADDR,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  input  logic [31:0]      PWDATA,
  output logic             PREADY,
  output logic [31:0]      PRDATA,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);
  logic [15:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             unused_bits;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] itype_q, itype_d;
  logic [WIDTH-1:0] ipol_q, ipol_d;
  logic [WIDTH-1:0] iboth_q, iboth_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] sin;
  logic [WIDTH-1:0] evt;

  assign addr        = PADDR[15:0];
  assign wdata       = PWDATA[WIDTH-1:0];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR[31:16], PWDATA};

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .pclk_i    (PCLK),
    .presetn_i (PRESETn),
    .gpio_i    (GPIO_IN),
    .itype_i   (itype_q),
    .ipol_i    (ipol_q),
    .iboth_i   (iboth_q),
    .sin_o     (sin),
    .evt_o     (evt)
  );

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ie_d    = ie_q;
    itype_d = itype_q;
    ipol_d  = ipol_q;
    iboth_d = iboth_q;
    w1c     = '0;
    if (wr_en) begin
      case (addr)
        DATA_OFF:    out_d   = wdata;
        DIR_OFF:     dir_d   = wdata;
        OUT_SET_OFF: out_d   = out_q | wdata;
        OUT_CLR_OFF: out_d   = out_q & ~wdata;
        OUT_TGL_OFF: out_d   = out_q ^ wdata;
        IE_OFF:      ie_d    = wdata;
        ITYPE_OFF:   itype_d = wdata;
        IPOL_OFF:    ipol_d  = wdata;
        IBOTH_OFF:   iboth_d = wdata;
        ISTAT_OFF:   w1c     = wdata;
        default:     ;
      endcase
    end
    // A new event outranks a clear landing on the same bit.
    istat_d = (istat_q & ~w1c) | evt;
    irq_d   = |(istat_q & ie_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_q   <= '0;
      dir_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ie_q    <= ie_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      iboth_q <= iboth_d;
      istat_q <= istat_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    PRDATA = DEFAULT_RDATA;
    case (addr)
      DATA_OFF:    PRDATA = 32'(sin);
      DIR_OFF:     PRDATA = 32'(dir_q);
      OUT_SET_OFF: PRDATA = 32'h0;
      OUT_CLR_OFF: PRDATA = 32'h0;
      OUT_TGL_OFF: PRDATA = 32'h0;
      IE_OFF:      PRDATA = 32'(ie_q);
      ITYPE_OFF:   PRDATA = 32'(itype_q);
      IPOL_OFF:    PRDATA = 32'(ipol_q);
      IBOTH_OFF:   PRDATA = 32'(iboth_q);
      ISTAT_OFF:   PRDATA = 32'(istat_q);
      IMSTAT_OFF:  PRDATA = 32'(istat_q & ie_q);
      default:     PRDATA = DEFAULT_RDATA;
    endcase
  end

  assign PREADY   = 1'b1;
  assign GPIO_OUT = out_q;
  assign GPIO_OE  = dir_q;
  assign IRQ      = irq_q;
endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: table-driven register vectors plus
// hand-written multi-cycle sequences, read data checked through a scoreboard.
module tb_apb_gpio_irq;
  localparam int WIDTH = 32;
  localparam int SS    = 2;

  localparam logic [31:0] A_DATA = 32'h00, A_DIR = 32'h04, A_SET = 32'h08, A_CLR = 32'h0C;
  localparam logic [31:0] A_TGL = 32'h10, A_IE = 32'h14, A_ITYPE = 32'h18, A_IPOL = 32'h1C;
  localparam logic [31:0] A_IBOTH = 32'h20, A_ISTAT = 32'h24, A_IMSTAT = 32'h28, A_BAD = 32'h30;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [31:0]      PADDR;
  logic             PWRITE;
  logic             PENABLE;
  logic             PSEL;
  logic [31:0]      PWDATA;
  logic             PREADY;
  logic [31:0]      PRDATA;
  logic [WIDTH-1:0] GPIO_IN;
  logic [WIDTH-1:0] GPIO_OUT;
  logic [WIDTH-1:0] GPIO_OE;
  logic             IRQ;

  always #5 PCLK = ~PCLK;

  apb_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .GPIO_IN  (GPIO_IN),
    .GPIO_OUT (GPIO_OUT),
    .GPIO_OE  (GPIO_OE),
    .IRQ      (IRQ)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          chk_out;
    string       name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   pready_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every read access-phase cycle pops one expectation.
  always @(negedge PCLK) begin : monitor
    sb_t e;
    if (PREADY !== 1'b1) pready_bad = 1'b1;
    if (PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got %08h expected no read", PRDATA);
      end else begin
        e = sb_q.pop_front();
        check(e.name, PRDATA, e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp, input bit chk_out, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.exp = exp; v.chk_out = chk_out; v.name = name;
    return v;
  endfunction

  task automatic expect_rd(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    expect_rd(name, exp);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; GPIO_IN = '1;

    vecs.push_back(mk(0, A_DIR,   0,            32'h0,        0, "dir_rst"));
    vecs.push_back(mk(0, A_BAD,   0,            32'hDEADBEEF, 0, "undef_rd"));
    vecs.push_back(mk(0, A_ISTAT, 0,            32'h0,        0, "istat_rst"));
    vecs.push_back(mk(0, A_DATA,  0,            32'hFFFFFFFF, 0, "data_in"));
    vecs.push_back(mk(1, A_DATA,  32'hF0,       32'hF0,       1, "out_data"));
    vecs.push_back(mk(1, A_SET,   32'h0F,       32'hFF,       1, "out_set"));
    vecs.push_back(mk(1, A_CLR,   32'h81,       32'h7E,       1, "out_clr"));
    vecs.push_back(mk(1, A_TGL,   32'hFF,       32'h81,       1, "out_tgl"));
    vecs.push_back(mk(0, A_SET,   0,            32'h0,        0, "set_rd0"));
    vecs.push_back(mk(0, A_TGL,   0,            32'h0,        0, "tgl_rd0"));
    vecs.push_back(mk(1, A_BAD,   32'hFFFFFFFF, 32'h81,       1, "undef_wr"));
    vecs.push_back(mk(1, A_DIR,   32'hA5A5A5A5, 0,            0, "dir_wr"));
    vecs.push_back(mk(0, A_DIR,   0,            32'hA5A5A5A5, 0, "dir_rw"));
    vecs.push_back(mk(1, A_ITYPE, 32'hFFFFFFFF, 0,            0, "itype_wr"));
    vecs.push_back(mk(1, A_IPOL,  32'hFFFFFFFF, 0,            0, "ipol_wr"));
    vecs.push_back(mk(0, A_IPOL,  0,            32'hFFFFFFFF, 0, "ipol_rw"));
    vecs.push_back(mk(0, A_IMSTAT,0,            32'h0,        0, "imstat_rst"));

    repeat (3) tick();
    check("out_rst", GPIO_OUT, 32'h0);
    check("oe_rst", GPIO_OE, 32'h0);
    check("irq_rst", 32'(IRQ), 32'h0);
    PRESETn = 1'b1;
    repeat (6) tick();

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data);
        if (vecs[i].chk_out) check(vecs[i].name, GPIO_OUT, vecs[i].exp);
      end else begin
        apb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
    end
    check("oe_dir", GPIO_OE, 32'hA5A5A5A5);

    // Falling edges are ignored while every pin is rising-edge type.
    GPIO_IN = '0;
    repeat (4) tick();
    apb_read(A_ISTAT, 32'h0, "fall_ignored");

    // Sync latency: DATA[3] appears exactly SS cycles after the pad change.
    PADDR = A_DATA; PWRITE = 1'b0; PSEL = 1'b1;
    tick();
    PENABLE = 1'b1;
    GPIO_IN[3] = 1'b1;
    expect_rd("sync_c1", 32'h0);
    expect_rd("sync_c2", 32'h0);
    expect_rd("sync_c3", 32'h8);
    expect_rd("sync_c4", 32'h8);
    repeat (4) tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(A_ISTAT, 32'h8, "rise_pin3");
    apb_write(A_ISTAT, 32'hFFFFFFFF);
    apb_read(A_ISTAT, 32'h0, "w1c_all");

    // Rising edge on pin 0 with IE: status then IRQ one cycle later.
    apb_write(A_IE, 32'h1);
    PADDR = A_ISTAT; PWRITE = 1'b0; PSEL = 1'b1;
    tick();
    PENABLE = 1'b1;
    GPIO_IN[0] = 1'b1;
    expect_rd("ist_c0", 32'h0);
    expect_rd("ist_c1", 32'h0);
    expect_rd("ist_c2", 32'h0);
    expect_rd("ist_c3", 32'h1);
    expect_rd("ist_c4", 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) GPIO_IN[0] = 1'b0;
      @(negedge PCLK);
      check($sformatf("irq_c%0d", i), 32'(IRQ), (i == 4) ? 32'h1 : 32'h0);
      @(posedge PCLK);
      #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_write(A_ISTAT, 32'h1);
    check("irq_hold", 32'(IRQ), 32'h1);
    tick();
    check("irq_clr", 32'(IRQ), 32'h0);
    apb_read(A_ISTAT, 32'h0, "istat_clr");

    // Level-low on pin 5: W1C cannot clear while the pin stays low.
    apb_write(A_ITYPE, 32'hFFFFFFDF);
    apb_write(A_IPOL, 32'hFFFFFFDF);
    apb_write(A_ISTAT, 32'hFFFFFFFF);
    apb_read(A_ISTAT, 32'h20, "level_resets");
    GPIO_IN[5] = 1'b1;
    repeat (4) tick();
    apb_write(A_ISTAT, 32'h20);
    apb_read(A_ISTAT, 32'h0, "level_gone");
    apb_write(A_ITYPE, 32'hFFFFFFFF);
    apb_write(A_IPOL, 32'hFFFFFFFF);
    apb_read(A_ISTAT, 32'h0, "cfg_restore");

    // Both-edge on pin 2, then a W1C landing on the same edge as a new event.
    apb_write(A_IBOTH, 32'h4);
    GPIO_IN[2] = 1'b1;
    repeat (4) tick();
    apb_read(A_ISTAT, 32'h4, "both_rise");
    GPIO_IN[2] = 1'b0;
    tick();
    apb_write(A_ISTAT, 32'h4);
    apb_read(A_ISTAT, 32'h4, "collision");
    apb_write(A_ISTAT, 32'h4);
    apb_read(A_ISTAT, 32'h0, "w1c_after");

    // Masked status on pin 7, then unmask.
    apb_write(A_IE, 32'h0);
    GPIO_IN[7] = 1'b1;
    repeat (4) tick();
    apb_read(A_ISTAT, 32'h80, "mask_stat");
    apb_read(A_IMSTAT, 32'h0, "mask_imstat");
    check("mask_irq", 32'(IRQ), 32'h0);
    apb_write(A_IE, 32'h80);
    apb_read(A_IMSTAT, 32'h80, "imstat_on");
    check("irq_unmask", 32'(IRQ), 32'h1);

    // Reset in the middle of an access, pads held high across release.
    GPIO_IN = '1;
    repeat (4) tick();
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_SET; PWDATA = 32'hFF;
    tick();
    PENABLE = 1'b1;
    #1;
    PRESETn = 1'b0;
    #1;
    check("rst_out", GPIO_OUT, 32'h0);
    check("rst_oe", GPIO_OE, 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (2) tick();
    PRESETn = 1'b1;
    repeat (8) tick();
    apb_read(A_ISTAT, 32'h0, "post_rst_istat");
    apb_read(A_DIR, 32'h0, "post_rst_dir");
    check("post_rst_irq", 32'(IRQ), 32'h0);

    tick();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    check("pready", 32'(pready_bad), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised APB GPIO port. Successor to the fixed 32-bit GPIO port. Sits on the APB peripheral bus.
- Adds configurable width and synchroniser depth.
- Adds atomic set/clear/toggle of output bits.
- Adds per-pin interrupt detection (level or edge, selectable polarity, optional both-edge), with a sticky W1C status register and a single registered IRQ line to the interrupt controller.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32); register bits above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2, flops in the GPIO_IN synchroniser chain (>=2).

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  reset
- PADDR  in  32  APB address; only PADDR[15:0] decoded
- PWRITE  in  1  write strobe
- PENABLE  in  1  APB access phase
- PSEL  in  1  slave select
- PWDATA  in  32  write data
- PREADY  out  1  always 1 (no wait states)
- PRDATA  out  32  read data (combinational from PADDR)
- GPIO_IN  in  WIDTH  asynchronous pad inputs
- GPIO_OUT  out  WIDTH  output data
- GPIO_OE  out  WIDTH  output enable, 1 = drive
- IRQ  out  1  level interrupt, registered

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK.
  - All registers and sync flops reset to 0, so GPIO_OUT=0, GPIO_OE=0, IRQ=0.
- Access: write when PSEL&PENABLE&PWRITE; read data valid whenever PSEL&PENABLE&~PWRITE. Register updates take effect on the PCLK edge ending the access phase.
- Register map (offsets):
  - 0x00 DATA: read = synchronised input; write = output register.
  - 0x04 DIR: RW.
  - 0x08 OUT_SET: W, out |= d; reads 0.
  - 0x0C OUT_CLR: W, out &= ~d; reads 0.
  - 0x10 OUT_TGL: W, out ^= d; reads 0.
  - 0x14 IE: RW interrupt enable.
  - 0x18 ITYPE: RW, 1 = edge, 0 = level.
  - 0x1C IPOL: RW; 1 = rising/high, 0 = falling/low.
  - 0x20 IBOTH: RW; 1 = both edges, only meaningful when ITYPE=1.
  - 0x24 ISTAT: read raw sticky status; write-1-to-clear.
  - 0x28 IMSTAT: RO, ISTAT&IE.
  - Any other offset reads 32'hDEADBEEF; writes to it are ignored.
- Synchroniser: GPIO_IN passes through SYNC_STAGES flops to give sin. One further flop holds sin_q for edge detection. DATA read latency is SYNC_STAGES cycles from a pad change.
- Event per bit i:
  - Edge, IBOTH=1: sin^sin_q.
  - Edge, IPOL=1: sin&~sin_q.
  - Edge, IPOL=0: ~sin&sin_q.
  - Level: sin==IPOL.
- Status:
  - ISTAT[i] is set on the edge after the event, regardless of IE. Status is recorded even when masked.
  - ISTAT[i] holds until a W1C write.
  - Level-type status re-sets every cycle while the level persists, so clearing is ineffective until the pin deasserts.
- Simultaneous event and W1C on the same bit in the same cycle: set wins.
- Config changes take effect immediately. Changing ITYPE/IPOL may generate a spurious event; software clears ISTAT afterwards.
- IRQ = registered |(ISTAT&IE); one cycle after ISTAT/IE change.
- DIR does not gate the input path; DATA reads the pad even for output pins.
- Reset mid-operation: everything clears asynchronously. The first cycle after reset must not raise edge events: sin_q resets to 0 and events are suppressed for SYNC_STAGES+1 cycles after reset release. Implement this with a small counter.

Decomposition:
- Shared package gpio_pkg:
  - Register offset localparams (DATA_OFF..IMSTAT_OFF).
  - DEFAULT_RDATA = 32'hDEADBEEF.
- One natural sub-module: gpio_sync_edge, the per-vector synchroniser plus edge/level event generator. Its parameters are WIDTH and SYNC_STAGES.
- The APB register file and ISTAT logic stay in the top.

Test Plan:
- Reset/default: after reset, read DIR -> 0; read 0x30 -> DEADBEEF; GPIO_OUT=0; IRQ=0; PREADY=1 throughout.
- Atomic ops:
  - write DATA=0x0000_00F0, OUT_SET=0x0F -> GPIO_OUT=0xFF.
  - OUT_CLR=0x81 -> 0x7E.
  - OUT_TGL=0xFF -> 0x81.
  - read OUT_SET -> 0.
- Sync latency: toggle GPIO_IN[3] 0->1 -> DATA[3] reads 1 exactly SYNC_STAGES cycles later, not earlier.
- Rising edge IRQ:
  - Setup: IE=0x1, ITYPE=0x1, IPOL=0x1; pulse GPIO_IN[0] high for 4 cycles.
  - ISTAT=0x1; IRQ=1 one cycle after ISTAT sets.
  - W1C 0x1 -> ISTAT=0, IRQ=0 next cycle.
- Level and collision:
  - Level: ITYPE=0, IPOL=0 on pin 5 with pin held low; W1C ISTAT -> bit 5 reads 1 again.
  - Collision: with IBOTH=1, W1C pin 2 in the same cycle as an edge -> ISTAT[2] remains 1.
- Masking and reset: IE=0, edge on pin 7 -> ISTAT[7]=1, IMSTAT=0, IRQ=0. Assert PRESETn low mid-transfer -> all outputs 0 immediately. With GPIO_IN held 1 across reset release, no ISTAT bits set.
